// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb
//
// Parametrised two-read / one-write register file with a per-register busy
// scoreboard for a pipelined core. Decode reads operands and reserves its
// destination register. Writeback writes the result and releases the
// reservation. Register 0 is hardwired to zero and is never busy.
//
// Optional build macro:
//   REG_FILE_BYPASS_EN - when defined, a read of the register being written
//                        this cycle returns wr_data and reads as not busy
//                        (write-through forwarding). When undefined, reads
//                        show the pre-edge contents and scoreboard.
//
// Parameters:
//   DATA_W    register data width
//   ADDR_W    register index width, NREG = 2**ADDR_W
//   RESET_VAL reset value of registers 1..NREG-1 (truncated to DATA_W)
//
// Ports:
//   clk                  rising-edge clock
//   rst_n                asynchronous active-low reset
//   rd_addr_1/2          read indices
//   rd_data_1/2          read data (combinational)
//   rd_busy_1/2          selected register is reserved, value stale
//   wr_en/wr_addr/wr_data  writeback port, clears busy on write
//   rsv_en/rsv_addr      reserve request from decode
//   rsv_ok               reservation accepted this cycle (combinational)
//   busy_vec             current scoreboard, bit i = register i busy
// -----------------------------------------------------------------------------
module reg_file_sb #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_W-1:0]      rd_addr_1,
  input  logic [ADDR_W-1:0]      rd_addr_2,
  output logic [DATA_W-1:0]      rd_data_1,
  output logic [DATA_W-1:0]      rd_data_2,
  output logic                   rd_busy_1,
  output logic                   rd_busy_2,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   rsv_en,
  input  logic [ADDR_W-1:0]      rsv_addr,
  output logic                   rsv_ok,
  output logic [(2**ADDR_W)-1:0] busy_vec
);

  localparam int unsigned NREG = 2**ADDR_W;
  localparam logic [DATA_W-1:0] RESET_DATA = DATA_W'(RESET_VAL);

  logic [DATA_W-1:0] r_regs [NREG];
  logic [NREG-1:0]   r_busy;

  logic              w_wr_valid;
  logic              w_wr_hit_rsv;
  logic              w_rsv_ok;
  logic              w_rsv_set;
  logic [NREG-1:0]   w_busy_nxt;
  logic [DATA_W-1:0] w_rd_data_1;
  logic [DATA_W-1:0] w_rd_data_2;
  logic              w_rd_busy_1;
  logic              w_rd_busy_2;

  // Qualify write and reservation requests. While in reset nothing is accepted.
  always_comb begin
    w_wr_valid   = rst_n & wr_en & (wr_addr != {ADDR_W{1'b0}});
    // A write landing on the requested register frees it for a new producer.
    w_wr_hit_rsv = w_wr_valid & (wr_addr == rsv_addr);
    w_rsv_ok     = rst_n & rsv_en & (~r_busy[rsv_addr] | w_wr_hit_rsv);
    // Reserving r0 is accepted but never marks anything.
    w_rsv_set    = w_rsv_ok & (rsv_addr != {ADDR_W{1'b0}});
  end

  // Next scoreboard. The writeback clear is applied first, so a reserve of
  // the same index in the same cycle wins and leaves the register busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_valid) begin
      w_busy_nxt[wr_addr] = 1'b0;
    end else begin
      w_busy_nxt = r_busy;
    end
    if (w_rsv_set) begin
      w_busy_nxt[rsv_addr] = 1'b1;
    end else begin
      w_busy_nxt[0] = 1'b0;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Register array. Entry 0 is loaded with zero at reset and never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs[0] <= '0;
      for (int i = 1; i < NREG; i++) begin
        r_regs[i] <= RESET_DATA;
      end
    end else begin
      if (w_wr_valid) begin
        r_regs[wr_addr] <= wr_data;
      end
    end
  end

  // Read ports, with optional write-through forwarding.
  always_comb begin
`ifdef REG_FILE_BYPASS_EN
    if (w_wr_valid && (rd_addr_1 == wr_addr)) begin
      w_rd_data_1 = wr_data;
      w_rd_busy_1 = 1'b0;
    end else begin
      w_rd_data_1 = r_regs[rd_addr_1];
      w_rd_busy_1 = r_busy[rd_addr_1];
    end
    if (w_wr_valid && (rd_addr_2 == wr_addr)) begin
      w_rd_data_2 = wr_data;
      w_rd_busy_2 = 1'b0;
    end else begin
      w_rd_data_2 = r_regs[rd_addr_2];
      w_rd_busy_2 = r_busy[rd_addr_2];
    end
`else
    w_rd_data_1 = r_regs[rd_addr_1];
    w_rd_busy_1 = r_busy[rd_addr_1];
    w_rd_data_2 = r_regs[rd_addr_2];
    w_rd_busy_2 = r_busy[rd_addr_2];
`endif
  end

  assign rd_data_1 = w_rd_data_1;
  assign rd_data_2 = w_rd_data_2;
  assign rd_busy_1 = w_rd_busy_1;
  assign rd_busy_2 = w_rd_busy_2;
  assign rsv_ok    = w_rsv_ok;
  assign busy_vec  = r_busy;

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the 8x8 two-read/one-write register file used by the single-cycle MIPS datapath.
- Generalised in data width and register count; register 0 is hardwired to zero.
- Adds an asynchronous active-low reset and a per-register busy scoreboard (reserve on issue, clear on writeback) for a pipelined core.
- Sits between decode (read/reserve) and writeback (write).

Parameters:
- DATA_W, 8, register data width in bits
- ADDR_W, 3, register index width; register count NREG = 2**ADDR_W
- RESET_VAL, 0, value loaded into registers 1..NREG-1 on reset (truncated to DATA_W)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_addr_1  in  ADDR_W  read port 1 index
- rd_addr_2  in  ADDR_W  read port 2 index
- rd_data_1  out  DATA_W  read port 1 data
- rd_data_2  out  DATA_W  read port 2 data
- rd_busy_1  out  1  register at rd_addr_1 reserved, value stale
- rd_busy_2  out  1  register at rd_addr_2 reserved, value stale
- wr_en  in  1  write enable
- wr_addr  in  ADDR_W  write index
- wr_data  in  DATA_W  write data
- rsv_en  in  1  reserve request: mark rsv_addr busy
- rsv_addr  in  ADDR_W  register to reserve
- rsv_ok  out  1  reservation accepted this cycle
- busy_vec  out  NREG  current scoreboard, bit i = register i busy

Behaviour:
- Reset (rst_n low, asynchronous, no clock required):
  - registers 1..NREG-1 <= RESET_VAL
  - busy_vec <= 0
  - outputs follow combinationally from the reset state: rd_busy_* = 0, rsv_ok = 0
  - reset asserted mid-operation discards any write or reservation in that cycle
- Register 0:
  - always reads 0, never busy
  - writes to index 0 are ignored
  - reserve of index 0 gives rsv_ok = 1 but sets no bit
- Write: on rising clk with wr_en = 1 and wr_addr != 0, regs[wr_addr] <= wr_data and busy[wr_addr] <= 0.
- Read (combinational, zero latency):
  - rd_data_n = regs[rd_addr_n]
  - rd_busy_n = busy[rd_addr_n]
- Reserve (rsv_ok is combinational):
  - rsv_ok = rsv_en & ~busy[rsv_addr], with a same-cycle write to rsv_addr counting as already cleared
  - on rising clk, if rsv_ok and rsv_addr != 0, busy[rsv_addr] <= 1
  - reserving an already-busy register is refused (rsv_ok = 0, no state change); the requester stalls
- Simultaneous write and reserve:
  - same index: the reserve wins and busy ends at 1 (a new producer replaces the old); the data write still happens
  - different indices: both take effect
- No X propagation: every register has a defined value after reset.
- Single write port, so no write-write conflicts are possible.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN
- Defined:
  - a read whose index equals wr_addr while wr_en = 1 and wr_addr != 0 returns wr_data in the same cycle
  - rd_busy for that port reads 0
  - write-through forwarding, so no extra stall cycle
- Undefined:
  - reads return the pre-edge register contents
  - rd_busy reflects the pre-edge scoreboard
  - the new value is visible the cycle after the write edge

Test Plan:
- Reset: drive rst_n low mid-cycle with RESET_VAL = 8'h00 and registers previously written -> all reads 0 and busy_vec = 0 immediately, before any clk edge.
- Basic write/read: write 8'hA5 to r3, then 8'h3C to r7 -> rd_addr_1 = 3 gives 8'hA5, rd_addr_2 = 7 gives 8'h3C; both busy flags 0.
- Register 0: write 8'hFF to r0; reserve r0 -> rd_data for index 0 is 8'h00, rsv_ok = 1, busy_vec[0] stays 0.
- Scoreboard:
  - reserve r5 -> busy_vec = 8'b0010_0000
  - second reserve of r5 -> rsv_ok = 0
  - write 8'h11 to r5 -> busy cleared, data 8'h11
- Simultaneous write and reserve of r2 in one cycle -> rsv_ok = 1, r2 holds wr_data, busy_vec[2] = 1 after the edge.
- Bypass: write 8'h5A to r4 with rd_addr_1 = 4 in the same cycle -> with REG_FILE_BYPASS_EN, rd_data_1 = 8'h5A before the edge; without it, the old value before the edge and 8'h5A after.
